alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters, e.g. requester 0 = main execute path and requester 1 = address/branch helper.
- Each requester issues one operation with a valid/ready handshake.
- The arbiter grants at most one request per cycle, drives the shared ALU and registers the result into a per-requester response slot.
- Each response slot is held until its requester takes it with a valid/ready handshake.

Parameters:
- RR_EN, 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 wins.
- NUM_OPS, 10: number of legal ALU op codes (0..NUM_OPS-1). Codes at or above this value are flagged as illegal.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  synchronous active-high reset
- i_req0_valid  in  1  requester 0 has an operation
- i_req0_op_a  in  32  operand A
- i_req0_op_b  in  32  operand B
- i_req0_alu_op  in  4  ALU op code
- o_req0_ready  out  1  request 0 accepted this cycle
- i_req1_valid, i_req1_op_a, i_req1_op_b, i_req1_alu_op, o_req1_ready: same as requester 0
- o_rsp0_valid  out  1  response slot 0 holds a result
- o_rsp0_data  out  32  result
- o_rsp0_err  out  1  result came from an illegal op code
- i_rsp0_ready  in  1  requester 0 consumes the response
- o_rsp1_valid, o_rsp1_data, o_rsp1_err, i_rsp1_ready: same as requester 0
- o_alu_op_a  out  32  to shared ALU
- o_alu_op_b  out  32  to shared ALU
- o_alu_op  out  4  to shared ALU
- i_alu_data  in  32  ALU result (combinational)
- o_busy  out  1  any response slot valid, or a grant this cycle

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous, active-high.
- Reset values: all o_rsp*_valid, o_rsp*_data and o_rsp*_err = 0; round-robin pointer last_grant = 1, so requester 0 wins the first tie. Reset mid-operation discards any pending response and any grant in that cycle.
- Eligibility: requester N is eligible when i_reqN_valid = 1 and its slot is free. A slot is free when o_rspN_valid = 0, or when o_rspN_valid = 1 and i_rspN_ready = 1 in the same cycle (drain-and-refill bypass).
- Grant selection (combinational):
  - Only one requester eligible: grant it.
  - Both eligible with RR_EN = 1: grant the requester that is not last_grant.
  - Both eligible with RR_EN = 0: grant requester 0.
- o_reqN_ready = grantN. At most one ready is high per cycle. Ready may depend combinationally on both valids and both i_rsp*_ready.
- ALU drive, same cycle: on a grant, o_alu_op_a, o_alu_op_b and o_alu_op are the granted requester's fields. With no grant, they are all 0 (op 0 = ADD, result ignored).
- Response capture, latency 1: at the edge ending grant cycle T, the slot of the granted requester loads:
  - o_rspN_data = i_alu_data
  - o_rspN_err = (alu_op >= NUM_OPS)
  - o_rspN_valid = 1
  - last_grant = N
  The result is visible from cycle T+1.
- Illegal op: still executed; ALU returns 0 and err = 1. This is not a handshake error.
- Consume: when o_rspN_valid & i_rspN_ready and there is no new grant to N, valid clears next cycle. Data and err hold their last values.
- Simultaneous consume + grant to the same requester: the new result overwrites and valid stays 1. No bubble, no loss.
- A requester whose slot is full and not draining is never granted. Its request waits, and the other requester may proceed.
- Requester contract: valid must hold and operands must stay stable until ready. The arbiter does not check this.
- last_grant changes only on a grant. Idle cycles keep it.
- o_busy = |o_rsp*_valid | grant0 | grant1.

Test Plan:
- Reset then single request: req0 ADD 5+7 in cycle 1 -> o_req0_ready = 1 in cycle 1; o_rsp0_valid = 1, data = 12, err = 0 from cycle 2; req1 side idle; o_alu_op = 0 and operands 0 in idle cycles.
- Tie with RR_EN = 1: both valid every cycle, req0 SUB 10-3, req1 XOR 0xF0^0x0F, both i_rsp*_ready = 1 -> grants alternate 0,1,0,1…; data 7 and 0xFF. Same stimulus with RR_EN = 0 -> only req0 granted while it stays valid.
- Backpressure: req0 granted, i_rsp0_ready held 0; req0 issues again -> o_req0_ready stays 0 and req1 SLT (-1 < 1) is granted with result 1; raising i_rsp0_ready regrants req0 that same cycle; rsp0 shows new data next cycle and valid never drops.
- Illegal op: req1 op 4'hC, operands 0xFFFFFFFF,1 -> o_rsp1_data = 0, o_rsp1_err = 1; a following SRA 0x80000000>>4 gives 0xF8000000 with err = 0.
- Reset mid-stream: assert i_rst while both slots are valid and a grant is active -> next cycle all rsp valids = 0, and the first tie after reset is granted to req0.
- Shift/compare sweep through the arbiter: SLL 1<<31 = 0x80000000, SRL 0x80000000>>31 = 1, SLTU 1 < 0xFFFFFFFF = 1, AND/OR on 0xAAAA5555/0x0F0F0F0F -> 0x0A0A0505 / 0xAFAF5F5F.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: grants one op per cycle,
// registers each result into a per-requester response slot held until consumed.
module alu_arbiter #(
  parameter bit RR_EN   = 1'b1,
  parameter int NUM_OPS = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_valid,
  input  logic [31:0] i_req0_op_a,
  input  logic [31:0] i_req0_op_b,
  input  logic [3:0]  i_req0_alu_op,
  output logic        o_req0_ready,
  input  logic        i_req1_valid,
  input  logic [31:0] i_req1_op_a,
  input  logic [31:0] i_req1_op_b,
  input  logic [3:0]  i_req1_alu_op,
  output logic        o_req1_ready,
  output logic        o_rsp0_valid,
  output logic [31:0] o_rsp0_data,
  output logic        o_rsp0_err,
  input  logic        i_rsp0_ready,
  output logic        o_rsp1_valid,
  output logic [31:0] o_rsp1_data,
  output logic        o_rsp1_err,
  input  logic        i_rsp1_ready,
  output logic [31:0] o_alu_op_a,
  output logic [31:0] o_alu_op_b,
  output logic [3:0]  o_alu_op,
  input  logic [31:0] i_alu_data,
  output logic        o_busy
);

  localparam logic [4:0] OP_LIMIT = 5'(NUM_OPS);

  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] req_op_a [2];
  logic [31:0] req_op_b [2];
  logic [3:0]  req_alu_op [2];

  logic [1:0]  slot_free;
  logic [1:0]  eligible;
  logic [1:0]  grant;
  logic        op_illegal;

  logic [1:0]  rsp_valid_reg;
  logic [1:0]  rsp_err_reg;
  logic [31:0] rsp_data_reg [2];
  logic        last_grant_reg;
  logic        last_grant_next;

  assign req_valid     = {i_req1_valid, i_req0_valid};
  assign rsp_ready     = {i_rsp1_ready, i_rsp0_ready};
  assign req_op_a[0]   = i_req0_op_a;
  assign req_op_a[1]   = i_req1_op_a;
  assign req_op_b[0]   = i_req0_op_b;
  assign req_op_b[1]   = i_req1_op_b;
  assign req_alu_op[0] = i_req0_alu_op;
  assign req_alu_op[1] = i_req1_alu_op;

  // A full slot still counts as free when it is drained in the same cycle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
      assign slot_free[gi] = ~rsp_valid_reg[gi] | rsp_ready[gi];
      assign eligible[gi]  = req_valid[gi] & slot_free[gi];
    end
  endgenerate

  always_comb begin
    grant = 2'b00;
    if (!i_rst) begin
      if (eligible == 2'b11) begin
        grant = (RR_EN && !last_grant_reg) ? 2'b10 : 2'b01;
      end else begin
        grant = eligible;
      end
    end
  end

  always_comb begin
    o_alu_op_a = '0;
    o_alu_op_b = '0;
    o_alu_op   = '0;
    if (grant[0]) begin
      o_alu_op_a = req_op_a[0];
      o_alu_op_b = req_op_b[0];
      o_alu_op   = req_alu_op[0];
    end else if (grant[1]) begin
      o_alu_op_a = req_op_a[1];
      o_alu_op_b = req_op_b[1];
      o_alu_op   = req_alu_op[1];
    end
  end

  assign op_illegal = ({1'b0, o_alu_op} >= OP_LIMIT);

  always_comb begin
    last_grant_next = last_grant_reg;
    if (grant[0]) begin
      last_grant_next = 1'b0;
    end else if (grant[1]) begin
      last_grant_next = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant_reg <= 1'b1;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

  // A grant overrides a same-cycle consume, so valid never bubbles on refill.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          rsp_valid_reg[gi] <= 1'b0;
          rsp_err_reg[gi]   <= 1'b0;
          rsp_data_reg[gi]  <= '0;
        end else if (grant[gi]) begin
          rsp_valid_reg[gi] <= 1'b1;
          rsp_err_reg[gi]   <= op_illegal;
          rsp_data_reg[gi]  <= i_alu_data;
        end else if (rsp_ready[gi]) begin
          rsp_valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign o_req0_ready = grant[0];
  assign o_req1_ready = grant[1];
  assign o_rsp0_valid = rsp_valid_reg[0];
  assign o_rsp0_data  = rsp_data_reg[0];
  assign o_rsp0_err   = rsp_err_reg[0];
  assign o_rsp1_valid = rsp_valid_reg[1];
  assign o_rsp1_data  = rsp_data_reg[1];
  assign o_rsp1_err   = rsp_err_reg[1];
  assign o_busy       = (|rsp_valid_reg) | (|grant);

endmodule
